// File: rtl/inc_dec_pkg.sv
// Shared encodings for the increment/decrement/count unit: opcodes and FSM states.
package inc_dec_pkg;

    typedef logic [1:0] op_t;
    localparam op_t OP_INC   = 2'b00;
    localparam op_t OP_DEC   = 2'b01;
    localparam op_t OP_COUNT = 2'b10;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t BUSY = 1'b1;

endpackage

// File: rtl/inc_dec_if.sv
// Request/response bundle of the inc/dec unit, plus the FSM state for observation.
interface inc_dec_if #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 4
);
    import inc_dec_pkg::*;

    // valid/ready: a transfer happens on a rising edge where both are high;
    // the producer keeps valid and payload stable until that edge.
    logic              in_valid;
    logic              in_ready;
    op_t               op;
    logic [WIDTH-1:0]  operand;
    logic [STEP_W-1:0] step;
    logic              sat_en;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  result;
    logic [WIDTH-1:0]  iter;
    logic              zero;
    logic              carry;
    logic              ovf;
    logic              busy;
    logic              tick;
    state_t            fsm_state;

    modport master (
        output in_valid, op, operand, step, sat_en, out_ready,
        input  in_ready, out_valid, result, iter, zero, carry, ovf, busy, tick, fsm_state
    );

    modport slave (
        input  in_valid, op, operand, step, sat_en, out_ready,
        output in_ready, out_valid, result, iter, zero, carry, ovf, busy, tick, fsm_state
    );

endinterface

// File: rtl/inc_dec_core.sv
// Combinational add/subtract of two WIDTH-bit values with carry/borrow,
// signed-overflow detection and optional saturation.
module inc_dec_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic [WIDTH-1:0] value,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH:0] full;

    always_comb begin
        full  = '0;
        value = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        if (sub) begin
            // Bit WIDTH of the extended difference is the borrow (a < b).
            full  = {1'b0, a} - {1'b0, b};
            carry = full[WIDTH];
            ovf   = a[WIDTH-1] & ~full[WIDTH-1];
            value = (sat && carry) ? '0 : full[WIDTH-1:0];
        end else begin
            full  = {1'b0, a} + {1'b0, b};
            carry = full[WIDTH];
            ovf   = ~a[WIDTH-1] & full[WIDTH-1];
            value = (sat && carry) ? '1 : full[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/inc_dec_unit.sv
// Registered INC/DEC by a programmable step, plus a multi-cycle COUNT
// (repeated subtraction) returning iterations and remainder.
module inc_dec_unit #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    inc_dec_if.slave     bus
);
    import inc_dec_pkg::*;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] itr;
    logic [WIDTH-1:0] step_q;

    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] iter_q;
    logic             zero_q;
    logic             carry_q;
    logic             ovf_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic             core_sub;
    logic             core_sat;
    logic [WIDTH-1:0] core_value;
    logic             core_carry;
    logic             core_ovf;

    logic             accept;
    logic             count_done;

    // While BUSY the core is borrowed as a wrapping subtractor on the captured
    // count; its borrow doubles as the cnt < step comparison.
    always_comb begin
        core_a   = bus.operand;
        core_b   = WIDTH'(bus.step);
        core_sub = (bus.op != OP_INC);
        core_sat = bus.sat_en;
        if (state == BUSY) begin
            core_a   = cnt;
            core_b   = step_q;
            core_sub = 1'b1;
            core_sat = 1'b0;
        end
    end

    inc_dec_core #(.WIDTH(WIDTH)) u_core (
        .a     (core_a),
        .b     (core_b),
        .sub   (core_sub),
        .sat   (core_sat),
        .value (core_value),
        .carry (core_carry),
        .ovf   (core_ovf)
    );

    assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign count_done    = (state == BUSY) && ((step_q == '0) || core_carry);
    assign bus.busy      = (state == BUSY);
    assign bus.tick      = (state == BUSY) && !count_done;
    assign bus.fsm_state = state;

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.iter      = iter_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            itr         <= '0;
            step_q      <= '0;
            result_q    <= '0;
            iter_q      <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.op == OP_COUNT) begin
                            cnt    <= bus.operand;
                            itr    <= '0;
                            step_q <= WIDTH'(bus.step);
                            state  <= BUSY;
                        end else begin
                            result_q    <= core_value;
                            iter_q      <= '0;
                            zero_q      <= (core_value == '0);
                            carry_q     <= core_carry;
                            ovf_q       <= core_ovf;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (count_done) begin
                        result_q    <= cnt;
                        iter_q      <= itr;
                        zero_q      <= (cnt == '0);
                        carry_q     <= 1'b0;
                        ovf_q       <= (step_q == '0);
                        out_valid_q <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= core_value;
                        itr <= itr + WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inc_dec_unit.sv
// Randomized and directed checks of inc_dec_unit against an arithmetic reference model.
module tb_inc_dec_unit;
    import inc_dec_pkg::*;

    localparam int W  = 16;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    inc_dec_if #(.WIDTH(W), .STEP_W(SW)) bus ();

    inc_dec_unit #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    // packed as {result[34:19], iter[18:3], zero, carry, ovf}
    logic [34:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [34:0] model(input int op, input int a, input int s, input bit sat);
        int r, it, wrapped;
        bit c, o;
        it = 0;
        c  = 0;
        o  = 0;
        if (op == 2) begin
            if (s == 0) begin
                r = a;
                o = 1;
            end else begin
                it = a / s;
                r  = a % s;
            end
        end else if (op == 0) begin
            wrapped = (a + s) % 65536;
            c = (a + s) > 65535;
            o = (a < 32768) && (wrapped >= 32768);
            r = (c && sat) ? 65535 : wrapped;
        end else begin
            wrapped = (a - s + 65536) % 65536;
            c = a < s;
            o = (a >= 32768) && (wrapped < 32768);
            r = (c && sat) ? 0 : wrapped;
        end
        return {r[15:0], it[15:0], (r == 0), c, o};
    endfunction

    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [3:0] s, input logic sat);
        bit ok;
        ok = 0;
        bus.op       = op;
        bus.operand  = a;
        bus.step     = s;
        bus.sat_en   = sat;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            #1;
            ok = bus.in_ready;
            step_clk();
        end
        bus.in_valid = 1'b0;
        check("accepted", ok, 1);
        exp_q.push_back(model(op, a, s, sat));
        // Scramble inputs after acceptance: the unit must use captured values.
        bus.op      = 2'($urandom_range(0, 3));
        bus.operand = 16'($urandom);
        bus.step    = 4'($urandom);
        bus.sat_en  = 1'($urandom);
    endtask

    task automatic collect(input logic [1:0] op, output logic [34:0] got);
        int lat, ticks, busys;
        logic [34:0] exp;
        lat = 1;
        ticks = 0;
        busys = 0;
        while (!bus.out_valid && lat < 400) begin
            ticks += int'(bus.tick);
            busys += int'(bus.busy);
            step_clk();
            lat++;
        end
        check("out_valid", bus.out_valid, 1);
        got = {bus.result, bus.iter, bus.zero, bus.carry, bus.ovf};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("fields", got, exp);
        check("latency", lat, (op == OP_COUNT) ? int'(exp[18:3]) + 2 : 1);
        check("ticks", ticks, (op == OP_COUNT) ? int'(exp[18:3]) : 0);
        check("busy_cycles", busys, (op == OP_COUNT) ? int'(exp[18:3]) + 1 : 0);
    endtask

    task automatic consume(input int hold);
        logic [34:0] snap;
        snap = {bus.result, bus.iter, bus.zero, bus.carry, bus.ovf};
        for (int i = 0; i < hold; i++) begin
            step_clk();
            check("held_in_ready", bus.in_ready, 0);
            check("held_stable", {bus.out_valid, bus.result, bus.iter, bus.zero, bus.carry, bus.ovf}, {1'b1, snap});
        end
        bus.out_ready = 1'b1;
        step_clk();
        bus.out_ready = 1'b0;
        check("consumed", bus.out_valid, 0);
    endtask

    task automatic txn(input logic [1:0] op, input logic [15:0] a, input logic [3:0] s, input logic sat,
                       output logic [34:0] got);
        send(op, a, s, sat);
        collect(op, got);
        consume(int'($urandom_range(0, 2)));
    endtask

    initial begin
        logic [34:0] got;
        int seen;
        bus.in_valid  = 1'b0;
        bus.op        = OP_INC;
        bus.operand   = '0;
        bus.step      = '0;
        bus.sat_en    = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) step_clk();
        check("rst_outputs", {bus.out_valid, bus.result, bus.iter, bus.zero, bus.carry, bus.ovf, bus.busy, bus.tick}, '0);
        check("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        step_clk();

        // Directed cases
        txn(OP_DEC, 16'd11, 4'd1, 1'b0, got);
        check("dec11_result", got[34:19], 16'd10);
        check("dec11_flags", got[2:0], 3'b000);
        txn(OP_DEC, 16'h0000, 4'd1, 1'b0, got);
        check("dec0_wrap", {got[34:19], got[1]}, {16'hFFFF, 1'b1});
        txn(OP_DEC, 16'h0000, 4'd1, 1'b1, got);
        check("dec0_sat", {got[34:19], got[2], got[1]}, {16'h0000, 1'b1, 1'b1});
        txn(OP_INC, 16'h7FFF, 4'd1, 1'b0, got);
        check("inc7fff", {got[34:19], got[1], got[0]}, {16'h8000, 1'b0, 1'b1});
        txn(OP_INC, 16'hFFFF, 4'd1, 1'b1, got);
        check("incffff_sat", {got[34:19], got[1]}, {16'hFFFF, 1'b1});
        txn(OP_COUNT, 16'd10, 4'd3, 1'b0, got);
        check("count10_3", {got[34:19], got[18:3], got[2]}, {16'd1, 16'd3, 1'b0});
        txn(OP_COUNT, 16'd77, 4'd0, 1'b0, got);
        check("count_step0", {got[34:19], got[18:3], got[0]}, {16'd77, 16'd0, 1'b1});
        txn(2'b11, 16'd5, 4'd7, 1'b1, got);
        check("rsvd_as_dec", {got[34:19], got[1]}, {16'd0, 1'b1});

        // Backpressure then same-cycle consume + new request
        send(OP_INC, 16'd100, 4'd5, 1'b0);
        collect(OP_INC, got);
        for (int i = 0; i < 5; i++) begin
            step_clk();
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_stable", {bus.out_valid, bus.result}, {1'b1, 16'd105});
        end
        bus.out_ready = 1'b1;
        send(OP_DEC, 16'd50, 4'd8, 1'b0);
        bus.out_ready = 1'b0;
        check("b2b_valid", bus.out_valid, 1);
        check("b2b_result", bus.result, 16'd42);
        collect(OP_DEC, got);
        consume(0);

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            logic [1:0] op;
            logic [15:0] a;
            op = 2'($urandom_range(0, 3));
            a = (op == OP_COUNT) ? 16'($urandom_range(0, 200)) : 16'($urandom);
            txn(op, a, 4'($urandom), 1'($urandom), got);
        end

        // Reset in the middle of a long COUNT
        send(OP_COUNT, 16'd100, 4'd1, 1'b0);
        repeat (18) step_clk();
        check("mid_busy", bus.busy, 1);
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        void'(exp_q.pop_back());
        check("abort_outputs", {bus.out_valid, bus.result, bus.iter, bus.zero, bus.carry, bus.ovf, bus.busy, bus.tick}, '0);
        check("abort_in_ready", bus.in_ready, 1);
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            step_clk();
            seen += int'(bus.out_valid);
        end
        check("no_stale_result", seen, 0);

        // Reset wins over a simultaneous request
        bus.op = OP_COUNT;
        bus.operand = 16'd9;
        bus.step = 4'd2;
        bus.in_valid = 1'b1;
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_drops_req", {bus.busy, bus.out_valid}, 2'b00);
        repeat (3) step_clk();
        check("rst_drops_req_later", {bus.busy, bus.out_valid}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
